// File: rtl/execute_md.sv
// Execute stage with operand forwarding, ALU, destination select, M-stage register,
// and an iterative multiply/divide unit feeding HI/LO (one iteration per cycle).
module execute_md #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_write_e_i,
    input  logic              reg_dst_e_i,
    input  logic [1:0]        alu_src_e_i,
    input  logic [3:0]        alu_control_e_i,
    input  logic [3:0]        md_op_e_i,
    input  logic [2:0]        jump_e_i,
    input  logic              mem_write_e_i,
    input  logic              mem_to_reg_e_i,
    input  logic [DATA_W-1:0] pc_plus_4_e_i,
    input  logic [DATA_W-1:0] reg_data_1_e_i,
    input  logic [DATA_W-1:0] reg_data_2_e_i,
    input  logic [REG_W-1:0]  rt_e_i,
    input  logic [REG_W-1:0]  rd_e_i,
    input  logic [4:0]        shamt_e_i,
    input  logic [DATA_W-1:0] ext_imm_e_i,
    input  logic [DATA_W-1:0] result_w_i,
    input  logic [1:0]        forward_a_e_i,
    input  logic [1:0]        forward_b_e_i,
    input  logic              stall_m_i,
    output logic              stall_md_o,
    output logic              md_busy_o,
    output logic [REG_W-1:0]  write_reg_e_o,
    output logic              reg_write_m_o,
    output logic              mem_write_m_o,
    output logic              mem_to_reg_m_o,
    output logic [DATA_W-1:0] alu_out_m_o,
    output logic [DATA_W-1:0] write_data_m_o,
    output logic [REG_W-1:0]  write_reg_m_o
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    // ALU encoding: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT, 8 SLTU,
    // 9 SLL, 10 SRL, 11 SRA (B shifted by A[4:0]), 12 LUI (B << DATA_W/2), others 0
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t r_state, w_state_nxt;

    logic [DATA_W-1:0]   w_src_a, w_src_b, w_alu_a, w_alu_b, w_alu_out, w_result_e;
    logic [4:0]          w_sh;
    logic                w_md_start, w_md_any, w_issue, w_last, w_signed, w_is_div;
    logic                w_a_neg, w_b_neg;
    logic [DATA_W-1:0]   w_a_mag, w_b_mag;
    logic [DATA_W:0]     w_mul_sum, w_div_sh, w_div_trial;
    logic [2*DATA_W-1:0] w_mul_next, w_div_next, w_p_next, w_prod;
    logic [DATA_W-1:0]   w_quot, w_rem, w_hi_fin, w_lo_fin;

    logic [2*DATA_W-1:0] r_p;
    logic [DATA_W-1:0]   r_b, r_rs, r_hi, r_lo;
    logic                r_is_div, r_neg_q, r_neg_r, r_div0;
    logic [CNT_W-1:0]    r_cnt;

    always_comb begin
        case (forward_a_e_i)
            2'b01:   w_src_a = result_w_i;
            2'b10:   w_src_a = alu_out_m_o;
            default: w_src_a = reg_data_1_e_i;
        endcase
        case (forward_b_e_i)
            2'b01:   w_src_b = result_w_i;
            2'b10:   w_src_b = alu_out_m_o;
            default: w_src_b = reg_data_2_e_i;
        endcase
    end

    assign w_alu_a = alu_src_e_i[1] ? {{(DATA_W-5){1'b0}}, shamt_e_i} : w_src_a;
    assign w_alu_b = alu_src_e_i[0] ? ext_imm_e_i : w_src_b;
    assign w_sh    = w_alu_a[4:0];

    always_comb begin
        w_alu_out = '0;
        case (alu_control_e_i)
            4'd0:  w_alu_out = w_alu_a & w_alu_b;
            4'd1:  w_alu_out = w_alu_a | w_alu_b;
            4'd2:  w_alu_out = w_alu_a + w_alu_b;
            4'd3:  w_alu_out = w_alu_a ^ w_alu_b;
            4'd4:  w_alu_out = ~(w_alu_a | w_alu_b);
            4'd6:  w_alu_out = w_alu_a - w_alu_b;
            4'd7:  w_alu_out = {{(DATA_W-1){1'b0}}, ($signed(w_alu_a) < $signed(w_alu_b))};
            4'd8:  w_alu_out = {{(DATA_W-1){1'b0}}, (w_alu_a < w_alu_b)};
            4'd9:  w_alu_out = w_alu_b << w_sh;
            4'd10: w_alu_out = w_alu_b >> w_sh;
            4'd11: w_alu_out = $signed(w_alu_b) >>> w_sh;
            4'd12: w_alu_out = w_alu_b << (DATA_W/2);
            default: w_alu_out = '0;
        endcase
    end

    assign write_reg_e_o = jump_e_i[2] ? {REG_W{1'b1}} : (reg_dst_e_i ? rd_e_i : rt_e_i);
    assign w_result_e    = jump_e_i[2]          ? pc_plus_4_e_i :
                           (md_op_e_i == 4'd5)  ? r_hi :
                           (md_op_e_i == 4'd6)  ? r_lo : w_alu_out;

    assign w_md_start = (md_op_e_i >= 4'd1) && (md_op_e_i <= 4'd4);
    assign w_md_any   = (md_op_e_i >= 4'd1) && (md_op_e_i <= 4'd8);
    assign md_busy_o  = (r_state == S_BUSY);
    assign stall_md_o = md_busy_o && w_md_any;
    assign w_issue    = (r_state == S_IDLE) && w_md_start && !stall_m_i;
    assign w_last     = (r_state == S_BUSY) && (r_cnt == CNT_W'(DATA_W-1));

    // The iteration runs on magnitudes; signs are re-applied at the final write.
    assign w_signed = (md_op_e_i == 4'd1) || (md_op_e_i == 4'd3);
    assign w_is_div = (md_op_e_i == 4'd3) || (md_op_e_i == 4'd4);
    assign w_a_neg  = w_signed && w_src_a[DATA_W-1];
    assign w_b_neg  = w_signed && w_src_b[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -w_src_a : w_src_a;
    assign w_b_mag  = w_b_neg ? -w_src_b : w_src_b;

    // r_p holds {acc, multiplier} for mul and {remainder, quotient} for div.
    assign w_mul_sum   = {1'b0, r_p[2*DATA_W-1:DATA_W]} + (r_p[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});
    assign w_mul_next  = {w_mul_sum, r_p[DATA_W-1:1]};
    assign w_div_sh    = {r_p[2*DATA_W-1:DATA_W], r_p[DATA_W-1]};
    assign w_div_trial = w_div_sh - {1'b0, r_b};
    assign w_div_next  = w_div_trial[DATA_W] ? {w_div_sh[DATA_W-1:0], r_p[DATA_W-2:0], 1'b0}
                                             : {w_div_trial[DATA_W-1:0], r_p[DATA_W-2:0], 1'b1};
    assign w_p_next    = r_is_div ? w_div_next : w_mul_next;

    assign w_prod = r_neg_q ? -w_p_next : w_p_next;
    assign w_quot = r_neg_q ? -w_p_next[DATA_W-1:0] : w_p_next[DATA_W-1:0];
    assign w_rem  = r_neg_r ? -w_p_next[2*DATA_W-1:DATA_W] : w_p_next[2*DATA_W-1:DATA_W];

    always_comb begin
        w_hi_fin = w_prod[2*DATA_W-1:DATA_W];
        w_lo_fin = w_prod[DATA_W-1:0];
        if (r_is_div) begin
            w_hi_fin = r_div0 ? r_rs : w_rem;
            w_lo_fin = r_div0 ? {DATA_W{1'b1}} : w_quot;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p <= '0; r_b <= '0; r_rs <= '0; r_cnt <= '0;
            r_is_div <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_div0 <= 1'b0;
        end else if (w_issue) begin
            r_is_div <= w_is_div;
            r_b      <= w_is_div ? w_b_mag : w_a_mag;
            r_p      <= {{DATA_W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (w_src_b == '0);
            r_rs     <= w_src_a;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_hi_fin;
            r_lo <= w_lo_fin;
        end else if (!stall_md_o && !stall_m_i) begin
            if (md_op_e_i == 4'd7) r_hi <= w_src_a;
            if (md_op_e_i == 4'd8) r_lo <= w_src_a;
        end
    end

    // M stage: a held M wins, then a bubble behind a stalled mul/div-class op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_write_m_o <= 1'b0; mem_write_m_o <= 1'b0; mem_to_reg_m_o <= 1'b0;
            alu_out_m_o <= '0; write_data_m_o <= '0; write_reg_m_o <= '0;
        end else if (!stall_m_i) begin
            if (stall_md_o) begin
                reg_write_m_o <= 1'b0; mem_write_m_o <= 1'b0; mem_to_reg_m_o <= 1'b0;
                alu_out_m_o <= '0; write_data_m_o <= '0; write_reg_m_o <= '0;
            end else begin
                reg_write_m_o  <= reg_write_e_i;
                mem_write_m_o  <= mem_write_e_i;
                mem_to_reg_m_o <= mem_to_reg_e_i;
                alu_out_m_o    <= w_result_e;
                write_data_m_o <= w_src_b;
                write_reg_m_o  <= write_reg_e_o;
            end
        end
    end
endmodule

// File: tb/tb_execute_md.sv
// Randomized and directed bench for execute_md against an arithmetic reference
// model of HI/LO, mul/div latency and the M-stage register.
module tb_execute_md;
    localparam int W = 32;

    logic          clk = 1'b0, rst;
    logic          reg_write, reg_dst, mem_write, mem_to_reg, stall_m;
    logic [1:0]    alu_src, fwd_a, fwd_b;
    logic [3:0]    alu_ctl, md_op;
    logic [2:0]    jump;
    logic [W-1:0]  pc4, rd1, rd2, imm, result_w;
    logic [4:0]    rt, rd, shamt;
    logic          stall_md_o, md_busy_o, reg_write_m_o, mem_write_m_o, mem_to_reg_m_o;
    logic [4:0]    write_reg_e_o, write_reg_m_o;
    logic [W-1:0]  alu_out_m_o, write_data_m_o;

    always #5 clk = ~clk;

    execute_md #(.DATA_W(W), .REG_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .reg_write_e_i(reg_write), .reg_dst_e_i(reg_dst),
        .alu_src_e_i(alu_src), .alu_control_e_i(alu_ctl), .md_op_e_i(md_op), .jump_e_i(jump),
        .mem_write_e_i(mem_write), .mem_to_reg_e_i(mem_to_reg), .pc_plus_4_e_i(pc4),
        .reg_data_1_e_i(rd1), .reg_data_2_e_i(rd2), .rt_e_i(rt), .rd_e_i(rd), .shamt_e_i(shamt),
        .ext_imm_e_i(imm), .result_w_i(result_w), .forward_a_e_i(fwd_a), .forward_b_e_i(fwd_b),
        .stall_m_i(stall_m), .stall_md_o(stall_md_o), .md_busy_o(md_busy_o),
        .write_reg_e_o(write_reg_e_o), .reg_write_m_o(reg_write_m_o), .mem_write_m_o(mem_write_m_o),
        .mem_to_reg_m_o(mem_to_reg_m_o), .alu_out_m_o(alu_out_m_o), .write_data_m_o(write_data_m_o),
        .write_reg_m_o(write_reg_m_o)
    );

    int nvec = 0, nerr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference state
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo, e_alu, e_wd;
    logic [4:0]   e_wr;
    logic         e_rw, e_mw, e_mr, s_stall, s_busy;
    int           m_cnt;

    task automatic model_reset();
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_cnt = 0;
        e_alu = '0; e_wd = '0; e_wr = '0; e_rw = 0; e_mw = 0; e_mr = 0;
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  return (a < b) ? 1 : 0;
            4'd9:  return b << a[4:0];
            4'd10: return b >> a[4:0];
            4'd11: return $signed(b) >>> a[4:0];
            4'd12: return b << 16;
            default: return '0;
        endcase
    endfunction

    task automatic ref_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sp;
        logic [63:0] up;
        logic signed [W-1:0] sa, sb;
        sa = a; sb = b; hi = '0; lo = '0;
        case (op)
            4'd1: begin sp = longint'(sa) * longint'(sb); {hi, lo} = sp; end
            4'd2: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
            4'd3: begin
                if (b == 0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    // One E cycle: check combinational outputs, advance model, check M after the edge.
    task automatic cycle();
        logic busy, stall, start;
        logic [W-1:0] fa, fb, aa, bb, res;
        logic [4:0] wr;
        #1;
        busy  = m_cnt > 0;
        start = md_op >= 1 && md_op <= 4;
        stall = busy && md_op >= 1 && md_op <= 8;
        fa = (fwd_a == 2'b01) ? result_w : (fwd_a == 2'b10) ? e_alu : rd1;
        fb = (fwd_b == 2'b01) ? result_w : (fwd_b == 2'b10) ? e_alu : rd2;
        aa = alu_src[1] ? {27'b0, shamt} : fa;
        bb = alu_src[0] ? imm : fb;
        res = jump[2] ? pc4 : (md_op == 5) ? m_hi : (md_op == 6) ? m_lo : ref_alu(alu_ctl, aa, bb);
        wr  = jump[2] ? 5'h1f : (reg_dst ? rd : rt);
        s_stall = stall_md_o;
        s_busy  = md_busy_o;
        check("stall_md", stall_md_o, stall);
        check("md_busy", md_busy_o, busy);
        check("write_reg_e", write_reg_e_o, wr);
        if (busy) begin
            m_cnt--;
            if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (start && !stall_m) begin
            ref_md(md_op, fa, fb, p_hi, p_lo);
            m_cnt = W;
        end else if (!stall_m && md_op == 7) m_hi = fa;
        else if (!stall_m && md_op == 8) m_lo = fa;
        if (!stall_m) begin
            if (stall) begin
                e_rw = 0; e_mw = 0; e_mr = 0; e_alu = '0; e_wd = '0; e_wr = '0;
            end else begin
                e_rw = reg_write; e_mw = mem_write; e_mr = mem_to_reg;
                e_alu = res; e_wd = fb; e_wr = wr;
            end
        end
        @(posedge clk);
        #1;
        check("reg_write_m", reg_write_m_o, e_rw);
        check("mem_write_m", mem_write_m_o, e_mw);
        check("mem_to_reg_m", mem_to_reg_m_o, e_mr);
        check("alu_out_m", alu_out_m_o, e_alu);
        check("write_data_m", write_data_m_o, e_wd);
        check("write_reg_m", write_reg_m_o, e_wr);
    endtask

    task automatic instr(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        md_op = op; alu_ctl = 4'd2; rd1 = a; rd2 = b; fwd_a = 0; fwd_b = 0; alu_src = 0;
        jump = 0; reg_write = (op == 0 || op == 5 || op == 6); reg_dst = 1; mem_write = 0;
        mem_to_reg = 0; rt = 5'd2; rd = 5'd3; shamt = 0; imm = 0; pc4 = 32'h100; result_w = 0;
        cycle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && md_busy_o; i++) instr(0, 0, 0);
        check("idle_bound", md_busy_o, 0);
    endtask

    task automatic read_hilo(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo);
        wait_idle();
        instr(6, 0, 0);
        check({tag, "_lo"}, alu_out_m_o, lo);
        instr(5, 0, 0);
        check({tag, "_hi"}, alu_out_m_o, hi);
    endtask

    task automatic rand_instr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 10)      md_op = 4'($urandom_range(1, 4));
        else if (r < 20) md_op = 4'($urandom_range(5, 6));
        else if (r < 25) md_op = 4'($urandom_range(7, 8));
        else if (r < 28) md_op = 4'($urandom_range(9, 15));
        else             md_op = 0;
        alu_ctl = 4'($urandom_range(0, 15));
        rd1 = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        rd2 = ($urandom_range(0, 9) == 0) ? '0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
        fwd_a = 2'($urandom); fwd_b = 2'($urandom); alu_src = 2'($urandom);
        jump = ($urandom_range(0, 9) == 0) ? 3'b100 : 3'b000;
        reg_write = 1'($urandom); reg_dst = 1'($urandom); mem_write = 1'($urandom);
        mem_to_reg = 1'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
        imm = $urandom; pc4 = $urandom; result_w = $urandom;
        stall_m = ($urandom_range(0, 9) == 0);
    endtask

    int n;
    logic [W-1:0] saved;

    initial begin
        rst = 1; stall_m = 0;
        md_op = 0; alu_ctl = 0; rd1 = 0; rd2 = 0; fwd_a = 0; fwd_b = 0; alu_src = 0; jump = 0;
        reg_write = 0; reg_dst = 0; mem_write = 0; mem_to_reg = 0; rt = 0; rd = 0; shamt = 0;
        imm = 0; pc4 = 0; result_w = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_out", alu_out_m_o, 0);
        check("rst_reg_write", reg_write_m_o, 0);
        check("rst_busy", md_busy_o, 0);
        rst = 0;

        // MULT -3*7 followed by a stalled MFLO
        instr(1, -32'sd3, 32'd7);
        n = 0;
        for (int i = 0; i < 40; i++) begin instr(6, 0, 0); if (!s_stall) break; n++; end
        check("mult_stall_cycles", n, 32);
        check("mult_lo", alu_out_m_o, 32'hFFFF_FFEB);
        instr(5, 0, 0);
        check("mult_hi", alu_out_m_o, 32'hFFFF_FFFF);

        // DIVU 100/7 with an ADD flowing through while busy
        instr(4, 32'd100, 32'd7);
        instr(0, 32'd3, 32'd4);
        check("add_no_stall", s_stall, 0);
        check("add_during_busy", alu_out_m_o, 32'd7);
        read_hilo("divu", 32'd2, 32'd14);

        instr(3, -32'sd7, 32'd2);           read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        instr(3, 32'd5, 32'd0);             read_hilo("div_zero", 32'd5, 32'hFFFF_FFFF);
        instr(3, 32'h8000_0000, 32'hFFFF_FFFF); read_hilo("div_ovf", 32'd0, 32'h8000_0000);

        // back-to-back MULTU: the second one waits the full latency
        instr(2, '1, '1);
        n = 0;
        for (int i = 0; i < 40; i++) begin instr(2, '1, '1); if (!s_stall) break; n++; end
        check("multu_b2b_stall", n, 32);
        read_hilo("multu", 32'hFFFF_FFFE, 32'd1);

        // stall_m during busy: M frozen, unit completes on schedule
        instr(1, 32'd5, 32'd6);
        n = 0;
        for (int i = 0; i < 3; i++) begin instr(0, i, 1); n += s_busy; end
        saved = alu_out_m_o;
        stall_m = 1;
        for (int i = 0; i < 3; i++) begin instr(0, 100 + i, 0); n += s_busy; check("m_frozen", alu_out_m_o, saved); end
        stall_m = 0;
        for (int i = 0; i < 40 && md_busy_o; i++) begin instr(0, 0, 0); n += s_busy; end
        check("busy_cycles_with_stall_m", n, 32);
        read_hilo("mult_stallm", 32'd0, 32'd30);

        // reset at iteration 10
        instr(1, 32'd3, 32'd5);
        repeat (10) instr(0, 0, 0);
        rst = 1;
        #1;
        check("midrst_busy", md_busy_o, 0);
        check("midrst_stall", stall_md_o, 0);
        check("midrst_alu", alu_out_m_o, 0);
        check("midrst_wd", write_data_m_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        read_hilo("after_rst", 32'd0, 32'd0);

        // randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            rand_instr();
            cycle();
        end
        stall_m = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
